// File: rtl/serial_subtractor_4bit.sv
// Bit-serial subtractor: diff = (x - y - bin) mod 2^WIDTH, LSB first, one bit per clock
// through a single full-subtractor cell with a registered borrow.
//
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous, active-high reset
//   start  - operation request, accepted in IDLE or DONE
//   x, y   - minuend / subtrahend, sampled on acceptance
//   bin    - borrow-in, sampled on acceptance
//   diff   - registered result of the last completed operation
//   borrow - registered borrow-out of the last completed operation (x < y + bin)
//   busy   - high while bits are being shifted through the cell
//   done   - one-cycle pulse when diff/borrow have just been updated
module serial_subtractor_4bit #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             br_q, br_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;

    // Full-subtractor cell on the current LSBs.
    logic d_bit;
    logic br_next;
    assign d_bit   = a_q[0] ^ b_q[0] ^ br_q;
    assign br_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;

        unique case (state_q)
            StIdle, StDone: begin
                // DONE accepts a new start so back-to-back operations cost WIDTH+1 cycles.
                if (start) begin
                    a_d     = x;
                    b_d     = y;
                    br_d    = bin;
                    cnt_d   = '0;
                    state_d = StShift;
                end else begin
                    state_d = StIdle;
                end
            end
            StShift: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = br_next;
                res_d = {d_bit, res_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    // Publish only complete results; diff never shows partial bits.
                    diff_d   = {d_bit, res_q[WIDTH-1:1]};
                    borrow_d = br_next;
                    state_d  = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign diff   = diff_q;
    assign borrow = borrow_q;
    assign busy   = (state_q == StShift);
    assign done   = (state_q == StDone);

endmodule

// File: tb/tb_serial_subtractor_4bit.sv
module tb_serial_subtractor_4bit;

    localparam int unsigned WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             bin;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             busy;
    logic             done;

    int n_cmp = 0;
    int n_err = 0;

    serial_subtractor_4bit #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .x      (x),
        .y      (y),
        .bin    (bin),
        .diff   (diff),
        .borrow (borrow),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the sampled operands.
    function automatic logic [WIDTH-1:0] ref_diff(input int ox, input int oy, input int ob);
        int r;
        r = (ox - oy - ob) % (1 << WIDTH);
        if (r < 0) r += (1 << WIDTH);
        return WIDTH'(r);
    endfunction

    function automatic logic ref_borrow(input int ox, input int oy, input int ob);
        return (ox < oy + ob);
    endfunction

    // One full operation with a one-cycle start pulse; checks busy/done timing and result.
    task automatic do_op(input logic [WIDTH-1:0] ox, input logic [WIDTH-1:0] oy,
                         input logic ob, input string tag);
        logic [WIDTH-1:0] ed;
        logic             eb;
        ed = ref_diff(int'(ox), int'(oy), int'(ob));
        eb = ref_borrow(int'(ox), int'(oy), int'(ob));
        @(negedge clk);
        x = ox; y = oy; bin = ob; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Operands may change freely once accepted.
        x = WIDTH'($urandom); y = WIDTH'($urandom); bin = 1'($urandom);
        for (int i = 0; i < WIDTH; i++) begin
            check({tag, " busy"}, 32'(busy), 32'd1);
            check({tag, " no-done"}, 32'(done), 32'd0);
            @(negedge clk);
        end
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " busy-in-done"}, 32'(busy), 32'd0);
        check({tag, " diff"}, 32'(diff), 32'(ed));
        check({tag, " borrow"}, 32'(borrow), 32'(eb));
        @(negedge clk);
        check({tag, " done-pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int pulses;
        logic [WIDTH-1:0] seen_diff;
        logic             seen_borrow;

        rst = 1'b1; start = 1'b0; x = '0; y = '0; bin = 1'b0;
        #1;
        check("reset diff", 32'(diff), 32'd0);
        check("reset borrow", 32'(borrow), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases.
        do_op(4'd9, 4'd3, 1'b0, "9-3");
        do_op(4'd3, 4'd9, 1'b0, "3-9");
        do_op(4'd0, 4'd0, 1'b1, "0-0-1");
        do_op(4'd15, 4'd15, 1'b1, "15-15-1");
        do_op(4'd8, 4'd7, 1'b1, "8-7-1");

        // start during busy must be ignored.
        @(negedge clk);
        x = 4'd9; y = 4'd3; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        x = 4'd1; y = 4'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pulses = 0; seen_diff = '0; seen_borrow = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (done) begin
                pulses++;
                seen_diff = diff;
                seen_borrow = borrow;
            end
            @(negedge clk);
        end
        check("ignore pulses", 32'(pulses), 32'd1);
        check("ignore diff", 32'(seen_diff), 32'd6);
        check("ignore borrow", 32'(seen_borrow), 32'd0);

        // Asynchronous reset in the second SHIFT cycle aborts the operation.
        @(negedge clk);
        x = 4'd12; y = 4'd5; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort diff", 32'(diff), 32'd0);
        check("abort borrow", 32'(borrow), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (done || busy) pulses++;
            @(negedge clk);
        end
        check("abort quiet", 32'(pulses), 32'd0);
        do_op(4'd12, 4'd5, 1'b0, "12-5");

        // start held high: one op per WIDTH+1 cycles, accepted in DONE.
        @(negedge clk);
        x = 4'd5; y = 4'd1; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        for (int op = 0; op < 3; op++) begin
            for (int i = 0; i < WIDTH; i++) begin
                check("held busy", 32'(busy), 32'd1);
                check("held no-done", 32'(done), 32'd0);
                @(negedge clk);
            end
            check("held done", 32'(done), 32'd1);
            check("held busy-in-done", 32'(busy), 32'd0);
            check("held diff", 32'(diff), 32'd4);
            check("held borrow", 32'(borrow), 32'd0);
            if (op == 2) start = 1'b0;
            @(negedge clk);
        end
        check("held stop busy", 32'(busy), 32'd0);
        check("held stop done", 32'(done), 32'd0);

        // Randomized operations against the arithmetic model.
        for (int n = 0; n < 1000; n++) begin
            do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_subtractor_4bit.md
Name: serial_subtractor_4bit

Overview:
Multi-cycle, bit-serial subtractor. Computes diff = x - y - bin, LSB first, one bit per clock through a single full-subtractor cell with a registered borrow. It is the subtract-direction counterpart of the team's combinational 4-bit adder. It is intended for area-constrained datapaths and uses a start/busy/done handshake.

Parameters:
WIDTH, 4, operand and result width in bits (legal: >= 2)

Ports:
clk  input  1  clock, rising-edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled on rising clk edge
x  input  WIDTH  minuend; sampled only when start is accepted
y  input  WIDTH  subtrahend; sampled only when start is accepted
bin  input  1  borrow-in; sampled only when start is accepted
diff  output  WIDTH  registered result, (x - y - bin) mod 2^WIDTH
borrow  output  1  registered borrow-out, 1 when x < y + bin (unsigned)
busy  output  1  high while a subtraction is in progress
done  output  1  single-cycle pulse; diff/borrow updated in the same cycle

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values, taken immediately on rst=1 regardless of clk: diff=0, borrow=0, busy=0, done=0, state=IDLE, internal shift registers and bit counter cleared.
- States:
  - IDLE: if start=1, latch x, y and bin into shift registers a, b and borrow register br; counter=0; go to SHIFT. Otherwise stay.
  - SHIFT: each cycle:
    - d = a[0]^b[0]^br
    - br_next = (~a[0]&b[0]) | (~(a[0]^b[0])&br)
    - shift a and b right by 1; shift d into the MSB of the internal result register
    - counter increments
  - SHIFT exit: on the WIDTH-th SHIFT cycle, go to DONE. On that same edge, load diff with the completed result and borrow with br_next.
  - DONE: done=1 for exactly this cycle. Next state is IDLE, or SHIFT if start=1 (back-to-back accepted, operands latched as in IDLE).
- busy: 1 in SHIFT, 0 in IDLE and DONE.
- Latency: start sampled at edge k gives done=1 and valid diff/borrow after edge k+WIDTH. That is WIDTH cycles; throughput is one operation per WIDTH+1 cycles.
- start while busy=1 is ignored. It is not queued, and latched operands are unaffected.
- x, y and bin may change freely after acceptance; the result depends only on values sampled at acceptance.
- diff/borrow hold their last completed value until the next completion. They never show partial results during SHIFT.
- Arithmetic: unsigned, modulo 2^WIDTH.
  - borrow=1 exactly when x < y + bin.
  - Consistency: {~borrow, diff} == x + ~y + ~bin + ... is not required. The required identity is x - y - bin == diff - borrow*2^WIDTH.
- Reset mid-operation:
  - Abort; all outputs and state return to reset values.
  - No done pulse for the aborted operation.
  - The first start after rst deasserts is accepted normally.
- start held high continuously: one operation is accepted per WIDTH+1 cycles, each in a DONE cycle after the first.

Test Plan:
- Reset then x=9, y=3, bin=0, start 1 cycle: busy high 4 cycles; done pulses 4 cycles after start; diff=4'h6, borrow=0.
- x=3, y=9, bin=0: diff=4'hA, borrow=1. Also x=0, y=0, bin=1: diff=4'hF, borrow=1.
- x=15, y=15, bin=1: diff=4'hF, borrow=1. Also x=8, y=7, bin=1: diff=4'h0, borrow=0.
- Start x=9, y=3; assert start again with x=1, y=2 during busy: ignored; result diff=6, borrow=0; only one done pulse.
- Start x=12, y=5; assert rst in the 2nd SHIFT cycle: diff=0, borrow=0, busy=0 immediately; no done pulse. A following op x=12, y=5 gives diff=4'h7, borrow=0.
- start held high with x=5, y=1, bin=0 for 3 ops: done pulses every 5 cycles; diff=4 each time; busy low only during the DONE cycles. Random self-check of 1000 ops against x-y-bin.
